// File: rtl/timer_pkg.sv
// timer_pkg: opcodes, channel FSM states and BCD step helpers shared by multi_timer_core.
package timer_pkg;

    localparam int DIGIT_W = 16;

    localparam logic [2:0] OP_START    = 3'd0;
    localparam logic [2:0] OP_STOP     = 3'd1;
    localparam logic [2:0] OP_CLEAR    = 3'd2;
    localparam logic [2:0] OP_INC_SEC  = 3'd3;
    localparam logic [2:0] OP_INC_MIN  = 3'd4;
    localparam logic [2:0] OP_DIR_DOWN = 3'd5;
    localparam logic [2:0] OP_DIR_UP   = 3'd6;
    localparam logic [2:0] OP_ACK      = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // {carry, ss}: 59 wraps to 00 with carry
    function automatic logic [8:0] bcd_inc_ss(input logic [7:0] ss);
        return (ss == 8'h59)       ? {1'b1, 8'h00} :
               (ss[3:0] == 4'd9)   ? {1'b0, ss[7:4] + 4'd1, 4'd0} :
                                     {1'b0, ss[7:4], ss[3:0] + 4'd1};
    endfunction

    // {borrow, ss}: 00 wraps to 59 with borrow
    function automatic logic [8:0] bcd_dec_ss(input logic [7:0] ss);
        return (ss == 8'h00)       ? {1'b1, 8'h59} :
               (ss[3:0] == 4'd0)   ? {1'b0, ss[7:4] - 4'd1, 4'd9} :
                                     {1'b0, ss[7:4], ss[3:0] - 4'd1};
    endfunction

    // {carry, mm}: top wraps to 00 with carry
    function automatic logic [8:0] bcd_inc_mm(input logic [7:0] mm, input logic [7:0] top);
        return (mm == top)         ? {1'b1, 8'h00} :
               (mm[3:0] == 4'd9)   ? {1'b0, mm[7:4] + 4'd1, 4'd0} :
                                     {1'b0, mm[7:4], mm[3:0] + 4'd1};
    endfunction

    // minutes never decrement below 00 because countdown stops at 00:00
    function automatic logic [7:0] bcd_dec_mm(input logic [7:0] mm);
        return (mm == 8'h00)       ? 8'h00 :
               (mm[3:0] == 4'd0)   ? {mm[7:4] - 4'd1, 4'd9} :
                                     {mm[7:4], mm[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one mm:ss timer with IDLE/RUN/PAUSE/DONE control and BCD digit registers.
module timer_channel
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               cmd_hit,
    input  logic [2:0]         op,
    output logic [DIGIT_W-1:0] digits,
    output logic               running,
    output logic               dir_up,
    output logic               finish,
    output logic               alarm,
    output logic               err
);
    localparam logic [7:0] MM_TOP = to_bcd(MAX_MIN);

    state_t     st, st_n;
    logic [7:0] ss, ss_n, mm, mm_n, t_ss, t_mm, mm_dn;
    logic [8:0] ss_dn, ss_up, mm_up;
    logic       dir_n, err_n, tk, at_top, at_end, editable, can_start;

    always_comb begin
        ss_dn     = bcd_dec_ss(ss);
        ss_up     = bcd_inc_ss(ss);
        mm_dn     = bcd_dec_mm(mm);
        mm_up     = bcd_inc_mm(mm, MM_TOP);
        at_top    = mm_up[8] && ss_up[8];
        t_ss      = dir_up ? (at_top ? ss : ss_up[7:0]) : ss_dn[7:0];
        t_mm      = dir_up ? ((at_top || !ss_up[8]) ? mm : mm_up[7:0]) : (ss_dn[8] ? mm_dn : mm);
        at_end    = dir_up ? (t_mm == MM_TOP && t_ss == 8'h59) : ({t_mm, t_ss} == 16'h0000);
        tk        = tick && st == ST_RUN;
        editable  = st == ST_IDLE || st == ST_PAUSE;
        can_start = editable && (dir_up || {mm, ss} != 16'h0000);
        st_n      = tk ? (at_end ? ST_DONE : ST_RUN) : st;
        ss_n      = tk ? t_ss : ss;
        mm_n      = tk ? t_mm : mm;
        dir_n     = dir_up;
        err_n     = 1'b0;
        // the tick result above stands unless the command overrides it
        if (cmd_hit) begin
            case (op)
                OP_START: begin
                    st_n  = can_start ? ST_RUN : st_n;
                    err_n = !can_start;
                end
                OP_STOP:  st_n = (st_n == ST_RUN) ? ST_PAUSE : st_n;
                OP_CLEAR: begin
                    st_n = ST_IDLE;
                    ss_n = 8'h00;
                    mm_n = 8'h00;
                end
                OP_INC_SEC: begin
                    ss_n  = editable ? ss_up[7:0] : ss_n;
                    err_n = !editable;
                end
                OP_INC_MIN: begin
                    mm_n  = editable ? mm_up[7:0] : mm_n;
                    err_n = !editable;
                end
                OP_DIR_DOWN: begin
                    dir_n = (st == ST_IDLE) ? 1'b0 : dir_up;
                    err_n = st != ST_IDLE;
                end
                OP_DIR_UP: begin
                    dir_n = (st == ST_IDLE) ? 1'b1 : dir_up;
                    err_n = st != ST_IDLE;
                end
                OP_ACK:   st_n = (st == ST_DONE) ? ST_IDLE : st_n;
                default:  st_n = st_n;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= ST_IDLE;
            ss     <= 8'h00;
            mm     <= 8'h00;
            dir_up <= 1'b0;
            finish <= 1'b0;
            err    <= 1'b0;
        end else begin
            st     <= st_n;
            ss     <= ss_n;
            mm     <= mm_n;
            dir_up <= dir_n;
            finish <= st_n == ST_DONE && st != ST_DONE;
            err    <= err_n;
        end
    end

    assign digits  = {mm, ss};
    assign running = st == ST_RUN;
    assign alarm   = st == ST_DONE;

endmodule

// File: rtl/multi_timer_core.sv
// multi_timer_core: CHANNELS independent mm:ss timers sharing one prescaler and one command port.
module multi_timer_core
    import timer_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int TICK_DIV = 50_000_000,
    parameter  int MAX_MIN  = 99,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic                          CLK_50MHZ,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [CW-1:0]                 cmd_ch,
    input  logic [2:0]                    cmd_op,
    output logic                          cmd_err,
    output logic [DIGIT_W*CHANNELS-1:0]   digits,
    output logic [CHANNELS-1:0]           running,
    output logic [CHANNELS-1:0]           dir_up,
    output logic [CHANNELS-1:0]           finish,
    output logic [CHANNELS-1:0]           alarm
);
    logic [1:0]          sync;
    logic                rst_n, tick;
    logic [PW-1:0]       pre;
    logic [CHANNELS-1:0] hit, err;

    // asynchronous assertion, release synchronised through two flops
    always_ff @(posedge CLK_50MHZ or negedge reset) begin
        if (!reset) sync <= 2'b00;
        else        sync <= {sync[0], 1'b1};
    end

    assign rst_n     = sync[1];
    assign cmd_ready = rst_n;
    assign tick      = pre == PW'(TICK_DIV - 1);

    always_ff @(posedge CLK_50MHZ or negedge rst_n) begin
        if (!rst_n) pre <= '0;
        else        pre <= tick ? '0 : pre + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign hit[i] = cmd_valid && cmd_ready && cmd_ch == CW'(i);
        timer_channel #(.MAX_MIN(MAX_MIN)) u_ch (
            .clk     (CLK_50MHZ),
            .rst_n   (rst_n),
            .tick    (tick),
            .cmd_hit (hit[i]),
            .op      (cmd_op),
            .digits  (digits[i*DIGIT_W +: DIGIT_W]),
            .running (running[i]),
            .dir_up  (dir_up[i]),
            .finish  (finish[i]),
            .alarm   (alarm[i]),
            .err     (err[i])
        );
    end

    assign cmd_err = |err;

endmodule
